dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter placed in front of the single-ported data memory. It shares that memory between the pipeline MEM stage (port 0, CPU) and a secondary master (port 1, DMA/debug loader). Each granted access is a single-cycle beat; read data is returned registered one cycle later. The block provides CPU priority, a starvation guard for the DMA port and a DMA lock for multi-beat bursts. It drives the memory's write-enable, funct3, address and write-data inputs and consumes its combinational read-data output.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, byte address width
- STARVE_LIMIT, 4, consecutive denied DMA cycles before DMA is forced a grant (≥1)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request (load or store)
- cpu_we  in  1  1 = store, 0 = load
- cpu_funct3  in  3  access size/sign code (SB/SH/SW/LB/LH/LW/LBU/LHU encoding)
- cpu_addr  in  ADDR_WIDTH  byte address
- cpu_wdata  in  DATA_WIDTH  store data
- cpu_gnt  out  1  CPU beat accepted this cycle (combinational)
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  registered; load data valid for the CPU beat granted in the previous cycle
- dma_req, dma_we, dma_funct3, dma_addr, dma_wdata  in  1/1/3/ADDR_WIDTH/DATA_WIDTH  same meaning for port 1
- dma_lock  in  1  keep ownership after this beat (burst continues)
- dma_gnt  out  1  DMA beat accepted this cycle (combinational)
- dma_rvalid  out  1  registered; load data valid for the previous DMA beat
- rdata  out  DATA_WIDTH  registered load data, shared by both ports
- mem_wr_en  out  1  memory write enable
- mem_funct3  out  3  muxed funct3
- mem_addr  out  ADDR_WIDTH  muxed address
- mem_wr_data  out  DATA_WIDTH  muxed store data
- mem_rd_data  in  DATA_WIDTH  combinational memory read data

## Operation
- States: ARB (normal arbitration) and LOCK (DMA owns the memory).
- ARB grant order, evaluated each cycle:
  1. If dma_req and starve_cnt == STARVE_LIMIT, grant DMA.
  2. Otherwise, if cpu_req, grant CPU.
  3. Otherwise, if dma_req, grant DMA.
  4. Otherwise, no grant.
- LOCK: grant DMA whenever dma_req is high; CPU is never granted (cpu_stall follows cpu_req).
- ARB→LOCK: when dma_gnt & dma_lock.
- LOCK→ARB: when dma_gnt & ~dma_lock (last beat), or when ~dma_req (lock abandoned).
- starve_cnt: increments when dma_req & ~dma_gnt, saturating at STARVE_LIMIT. Clears on dma_gnt or ~dma_req. It is not incremented while in LOCK.
- At most one grant per cycle; cpu_gnt & dma_gnt is never 1.
- Memory mux: the granted port's funct3, address and wdata drive the memory, and mem_wr_en = granted port's we.
- With no grant: mem_wr_en = 0 and mem_addr/mem_funct3/mem_wr_data hold CPU port values.
- funct3 is passed through unchecked; size and sign handling belong to the memory.

## Timing
- Grant is combinational from the req inputs, the state and starve_cnt. The store commits at the rising edge ending the grant cycle.
- Load latency is 1 cycle. On a granted load, rdata <= mem_rd_data and the matching *_rvalid is set for exactly one cycle.
- Stores do not raise rvalid.
- rdata holds its last value when no load completes.
- Back-to-back beats from either port, or alternating between ports, are allowed every cycle at full throughput.
- The state is registered, so a LOCK entered on a beat takes effect in the next cycle.
- Reset (asynchronous, any cycle): state = ARB, starve_cnt = 0, cpu_rvalid = 0, dma_rvalid = 0, rdata = 0.
  - A pending rvalid is dropped and the lock is released.
  - mem_wr_en is 0 while rst_n is low.

## Test plan
- CPU-only load: cpu_req=1, we=0, funct3=010, addr=0x10, mem_rd_data=0xDEADBEEF → cpu_gnt=1 in the same cycle; next cycle cpu_rvalid=1 and rdata=0xDEADBEEF; dma_rvalid stays 0.
- Contention: cpu_req and dma_req held high, STARVE_LIMIT=4 → CPU granted 4 cycles, DMA granted on the 5th, then CPU again. The pattern repeats 4:1, and dma_gnt & cpu_gnt is never both 1.
- DMA burst: dma_req=1, dma_lock=1 for 3 beats then 0 on the 4th, cpu_req=1 throughout → 4 consecutive dma_gnt with mem_wr_en=dma_we and cpu_stall=1. CPU is granted in the cycle after the last beat.
- Abandoned lock: LOCK entered, then dma_req=0 → returns to ARB next cycle and a waiting CPU is granted that cycle.
- Store muxing: DMA SB with addr=0x3 and wdata=0xAB, no CPU request → mem_wr_en=1, mem_funct3=000, mem_addr=0x3, mem_wr_data=0xAB; no rvalid the following cycle.
- Reset mid-burst: assert rst_n=0 while in LOCK with a load pending → rvalid, rdata and starve_cnt all 0 immediately. After release, the first cycle with cpu_req=1 grants the CPU.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU priority, DMA starvation guard and DMA burst lock.
// Grants and the memory mux are combinational; load data and rvalids are registered.
module dmem_arbiter #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [2:0]            cpu_funct3,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_stall,
    output logic                  cpu_rvalid,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [2:0]            dma_funct3,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    input  logic                  dma_lock,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_wr_en,
    output logic [2:0]            mem_funct3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;

    // State and starvation counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Grant decision, next state and starvation count
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        cpu_gnt  = 1'b0;
        dma_gnt  = 1'b0;
        case (state_q)
            ARB: begin
                if (dma_req && (starve_q == CNT_MAX)) begin
                    dma_gnt = 1'b1;
                end else if (cpu_req) begin
                    cpu_gnt = 1'b1;
                end else if (dma_req) begin
                    dma_gnt = 1'b1;
                end
                if (dma_gnt && dma_lock) begin
                    state_d = LOCK;
                end
            end
            LOCK: begin
                dma_gnt = dma_req;
                if (!dma_req || !dma_lock) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
        // Saturating count of denied DMA cycles; only accrues during arbitration
        if (dma_gnt || !dma_req) begin
            starve_d = '0;
        end else if ((state_q == ARB) && (starve_q != CNT_MAX)) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    assign cpu_stall   = cpu_req & ~cpu_gnt;
    assign mem_wr_en   = rst_n & ((cpu_gnt & cpu_we) | (dma_gnt & dma_we));
    assign mem_funct3  = dma_gnt ? dma_funct3 : cpu_funct3;
    assign mem_addr    = dma_gnt ? dma_addr   : cpu_addr;
    assign mem_wr_data = dma_gnt ? dma_wdata  : cpu_wdata;

    // Registered load return; rdata keeps its value when no load completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
            rdata      <= '0;
        end else begin
            cpu_rvalid <= cpu_gnt & ~cpu_we;
            dma_rvalid <= dma_gnt & ~dma_we;
            if ((cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we)) begin
                rdata <= mem_rd_data;
            end
        end
    end

endmodule
